serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and default width for serial_adder
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_e        state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // Holds the upper WIDTH-1 partial sum bits; the newest bit is appended in s_next.
    logic [WIDTH-2:0] sh_s;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a   (sh_a[0]),
        .b   (sh_b[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign s_next = {fa_sum, sh_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        sh_s  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= s_next[WIDTH-1:1];
                    carry <= fa_cout;
                    if (cnt == LAST) begin
                        sum   <= s_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        ovf   <= carry ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout (cout),
        .ovf  (ovf)
`else
        .cout (cout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one addition (from IDLE or from the DONE cycle) and follow it to its done pulse.
    // noise: 0 = start low while shifting, 1 = start held high, 2 = random start.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input int noise, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int           lat;
        bit           seq_ok;
        exp    = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        held   = sum;
        a      = oa;
        b      = ob;
        cin    = oc;
        start  = 1'b1;
        step();
        seq_ok = 1'b1;
        lat    = 0;
        while (!done && lat < W + 3) begin
            if (busy !== 1'b1 || sum !== held) seq_ok = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
            step();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, W);
        check({tag, "_busy_hold"}, {31'd0, seq_ok}, 32'd1);
        check({tag, "_done_busy"}, {30'd0, done, busy}, 32'd2);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[W]});
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf},
              {31'd0, (oa[W-1] == ob[W-1]) && (exp[W-1] != oa[W-1])});
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sum"}, {24'd0, sum}, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        check_zero("idle");

        run_op(8'h5A, 8'h33, 1'b0, 0, "basic");
        step();
        check("basic_done_1cyc", {30'd0, done, busy}, 32'd0);
        check("basic_sum_held", {24'd0, sum}, 32'h8D);

        run_op(8'hFF, 8'h01, 1'b0, 0, "ripple1");
        step();
        run_op(8'hFF, 8'hFF, 1'b1, 0, "ripple2");
        step();

        run_op(8'h12, 8'h34, 1'b1, 1, "ignored_start");
        step();
        check("no_second_op", {30'd0, done, busy}, 32'd0);
        check("ignored_sum_held", {24'd0, sum}, 32'h47);

        run_op(8'h10, 8'h20, 1'b0, 0, "b2b_first");
        run_op(8'h01, 8'h02, 1'b0, 0, "b2b_second");
        step();

        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        run_op(8'h01, 8'h01, 1'b0, 0, "after_reset");
        step();

`ifdef SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0, "ovf_pos");
        step();
        run_op(8'hFF, 8'h01, 1'b0, 0, "ovf_none");
        step();
        run_op(8'h80, 8'h80, 1'b0, 0, "ovf_neg");
        step();
`endif

        run_op(8'h00, 8'h00, 1'b0, 0, "zero");
        run_op(8'hFF, 8'hFF, 1'b0, 0, "max");
        step();

        for (int n = 0; n < 1500; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 2, "rand");
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
        end
        step();
        check("final_idle", {30'd0, done, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
